// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier.
// Default widths and the controller-to-datapath control bundle.
package mul_pkg;

    localparam int MUL_WIDTH   = 16;
    localparam int MUL_P_WIDTH = 32;

    typedef struct packed {
        logic lda;
        logic ldb;
        logic ldp;
        logic clrp;
        logic decb;
    } mul_ctrl_t;

endpackage

// File: rtl/mul_down_counter.sv
// Loadable down-counter that saturates at zero.
// Drives the multiplier's B operand and its zero flag.
module mul_down_counter #(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    assign zero = (q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (dec && !zero) begin
            q <= q - 1'b1;
        end
    end

endmodule

// File: rtl/mul_datapath.sv
// Multiplier datapath: A register, B counter, P accumulator, result handshake.
// Define MUL_OVF_FLAG_EN to add the sticky ovf / res_ovf outputs.
module mul_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH   = MUL_WIDTH,
    parameter int P_WIDTH = MUL_P_WIDTH
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               LdA,
    input  logic               LdB,
    input  logic               LdP,
    input  logic               clrP,
    input  logic               decB,
    input  logic               done,
    output logic               eqz,
    output logic [P_WIDTH-1:0] result,
    output logic               res_valid,
    input  logic               res_ready
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic               ovf,
    output logic               res_ovf
`endif
);

    mul_ctrl_t          ctrl;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [P_WIDTH-1:0] p;
    logic [P_WIDTH-1:0] a_ext;
    logic [P_WIDTH-1:0] sum;
    logic               done_q;
    logic               cap;

    assign ctrl = '{lda: LdA, ldb: LdB, ldp: LdP, clrp: clrP, decb: decB};
    assign cap  = done & ~done_q;

    always_comb begin
        a_ext = '0;
        a_ext[WIDTH-1:0] = a;
    end

`ifdef MUL_OVF_FLAG_EN
    logic carry;
    assign {carry, sum} = {1'b0, p} + {1'b0, a_ext};
`else
    assign sum = p + a_ext;
`endif

    mul_down_counter #(.WIDTH(WIDTH)) u_b (
        .clk  (clk),
        .rst  (rst),
        .load (ctrl.ldb),
        .dec  (ctrl.decb),
        .d    (data_in),
        .q    (b),
        .zero (eqz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
        end else if (ctrl.lda) begin
            a <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (ctrl.clrp) begin
            p <= '0;
        end else if (ctrl.ldp) begin
            p <= sum;
        end
    end

    // Capture on done's rising edge wins over a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= 1'b0;
            result    <= '0;
            res_valid <= 1'b0;
        end else begin
            done_q <= done;
            if (cap) begin
                result    <= p;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MUL_OVF_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf     <= 1'b0;
            res_ovf <= 1'b0;
        end else begin
            if (ctrl.clrp) begin
                ovf <= 1'b0;
            end else if (ctrl.ldp && carry) begin
                ovf <= 1'b1;
            end
            if (cap) begin
                res_ovf <= ovf;
            end
        end
    end
`endif

    logic unused_b;
    assign unused_b = ^b;

endmodule

// File: tb/tb_mul_datapath.sv
// Bench for mul_datapath: a 16/32 and an 8/8 instance share one control bus.
// Table vectors, hand sequences and random traffic against a reference model.
module tb_mul_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        LdA = 0, LdB = 0, LdP = 0, clrP = 0, decB = 0;
    logic        done = 0, res_ready = 0;

    logic        eqz16, val16, eqz8, val8;
    logic [31:0] res16;
    logic [7:0]  res8;
    logic [7:0]  din8;
    assign din8 = data_in[7:0];

`ifdef MUL_OVF_FLAG_EN
    logic ovf16, rovf16, ovf8, rovf8;
`endif

    always #5 clk = ~clk;

    mul_datapath #(.WIDTH(16), .P_WIDTH(32)) dut16 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
        .done(done), .eqz(eqz16), .result(res16),
        .res_valid(val16), .res_ready(res_ready)
`ifdef MUL_OVF_FLAG_EN
        , .ovf(ovf16), .res_ovf(rovf16)
`endif
    );

    mul_datapath #(.WIDTH(8), .P_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .data_in(din8),
        .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
        .done(done), .eqz(eqz8), .result(res8),
        .res_valid(val8), .res_ready(res_ready)
`ifdef MUL_OVF_FLAG_EN
        , .ovf(ovf8), .res_ovf(rovf8)
`endif
    );

    int ntot = 0;
    int npass = 0;

    // Reference model: index 0 = 16/32 instance, index 1 = 8/8 instance.
    longint unsigned ma[2], mb[2], mp[2], mres[2];
    bit mv[2], movf[2], mrovf[2];
    bit mdone_prev;

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ma[k] = 0; mb[k] = 0; mp[k] = 0; mres[k] = 0;
            mv[k] = 0; movf[k] = 0; mrovf[k] = 0;
        end
        mdone_prev = 0;
    endtask

    task automatic model_step();
        longint unsigned wmax, pmod, s;
        bit rise;
        rise = done && !mdone_prev;
        for (int k = 0; k < 2; k++) begin
            wmax = (k == 0) ? 64'd65536 : 64'd256;
            pmod = (k == 0) ? 64'd4294967296 : 64'd256;
            if (rise) begin
                mres[k] = mp[k]; mrovf[k] = movf[k]; mv[k] = 1;
            end else if (mv[k] && res_ready) begin
                mv[k] = 0;
            end
            if (clrP) begin
                mp[k] = 0; movf[k] = 0;
            end else if (LdP) begin
                s = mp[k] + ma[k];
                if (s >= pmod) movf[k] = 1;
                mp[k] = s % pmod;
            end
            if (LdB) mb[k] = data_in % wmax;
            else if (decB && mb[k] > 0) mb[k] = mb[k] - 1;
            if (LdA) ma[k] = data_in % wmax;
        end
        mdone_prev = done;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".eqz16"}, eqz16, mb[0] == 0);
        chk({tag, ".val16"}, val16, mv[0]);
        chk({tag, ".res16"}, res16, mres[0]);
        chk({tag, ".eqz8"}, eqz8, mb[1] == 0);
        chk({tag, ".val8"}, val8, mv[1]);
        chk({tag, ".res8"}, res8, mres[1]);
`ifdef MUL_OVF_FLAG_EN
        chk({tag, ".ovf16"}, ovf16, movf[0]);
        chk({tag, ".rovf16"}, rovf16, mrovf[0]);
        chk({tag, ".ovf8"}, ovf8, movf[1]);
        chk({tag, ".rovf8"}, rovf8, mrovf[1]);
`endif
    endtask

    task automatic drive(input logic [15:0] d, input logic la, lb, lp,
                         cp, db, dn, rr);
        data_in = d; LdA = la; LdB = lb; LdP = lp;
        clrP = cp; decB = db; done = dn; res_ready = rr;
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        #1;
        model_step();
        chk_model(tag);
    endtask

    typedef struct {
        logic [15:0] d;
        logic la, lb, lp, cp, db, dn, rr;
        logic        e_eqz;
        logic [31:0] e_res;
        logic        e_val;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Normal multiply 17 x 5: expected outputs after each edge.
        tbl[0] = '{17, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{5,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{0,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{0,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[4] = '{0,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{0,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[6] = '{0,  0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
        tbl[7] = '{0,  0, 0, 0, 0, 0, 1, 0, 1, 85, 1};
        tbl[8] = '{0,  0, 0, 0, 0, 0, 0, 1, 1, 85, 0};
        tbl[9] = '{0,  0, 0, 0, 0, 0, 0, 0, 1, 85, 0};

        model_reset();
        #2;
        chk("rst.eqz", eqz16, 1);
        chk("rst.val", val16, 0);
        chk("rst.res", res16, 0);
        #10 rst = 0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].d, tbl[i].la, tbl[i].lb, tbl[i].lp,
                  tbl[i].cp, tbl[i].db, tbl[i].dn, tbl[i].rr);
            tick("t1");
            chk($sformatf("t1[%0d].eqz", i), eqz16, tbl[i].e_eqz);
            chk($sformatf("t1[%0d].res", i), res16, tbl[i].e_res);
            chk($sformatf("t1[%0d].val", i), val16, tbl[i].e_val);
        end

        // Zero operand: B saturates at 0.
        drive(0, 0, 1, 0, 0, 0, 0, 1); tick("t2");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 1); tick("t2");
            chk("t2.eqz", eqz16, 1);
        end
        drive(9, 1, 0, 0, 1, 0, 0, 1); tick("t2");
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick("t2");
        chk("t2.res", res16, 0);
        chk("t2.val", val16, 1);

        // Priority: clrP over LdP, LdB over decB.
        drive(3, 1, 0, 0, 1, 0, 0, 1); tick("t3");
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0, 1); tick("t3");
        end
        drive(7, 0, 1, 1, 1, 1, 0, 1); tick("t3");
        drive(0, 0, 0, 0, 0, 0, 1, 1); tick("t3");
        chk("t3.p_cleared", res16, 0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 1); tick("t3");
            chk($sformatf("t3.eqz_dec%0d", i + 1), eqz16, i == 6);
        end

        // Wrap on the 8-bit instance: 200 x 2 = 400 mod 256.
        drive(200, 1, 0, 0, 1, 0, 0, 1); tick("t4");
        drive(2, 0, 1, 0, 0, 0, 0, 1); tick("t4");
        drive(0, 0, 0, 1, 0, 1, 0, 1); tick("t4");
        drive(0, 0, 0, 1, 0, 1, 0, 1); tick("t4");
        chk("t4.eqz8", eqz8, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick("t4");
        chk("t4.res8", res8, 144);
        chk("t4.res16", res16, 400);
`ifdef MUL_OVF_FLAG_EN
        chk("t4.ovf8", ovf8, 1);
        chk("t4.rovf8", rovf8, 1);
        chk("t4.ovf16", ovf16, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 1); tick("t4");
        chk("t4.ovf8_clr", ovf8, 0);
`endif

        // Handshake: hold without ready, accept once, done stays high.
        drive(42, 1, 0, 0, 1, 0, 0, 1); tick("t5");
        drive(0, 0, 0, 1, 0, 0, 0, 1); tick("t5");
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0); tick("t5");
            chk("t5.val_hold", val16, 1);
            chk("t5.res_hold", res16, 42);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1); tick("t5");
        chk("t5.val_acc", val16, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 1, 0); tick("t5");
            chk("t5.no_recap", val16, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick("t5");

        // Async reset between edges with a pending result.
        drive(30, 1, 0, 0, 1, 0, 0, 0); tick("t6");
        drive(0, 0, 0, 1, 0, 0, 0, 0); tick("t6");
        drive(5, 0, 1, 0, 0, 0, 1, 0); tick("t6");
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick("t6");
        chk("t6.pre_val", val16, 1);
        chk("t6.pre_res", res16, 30);
        chk("t6.pre_eqz", eqz16, 0);
        #2 rst = 1;
        #1;
        model_reset();
        chk("t6.eqz", eqz16, 1);
        chk("t6.val", val16, 0);
        chk("t6.res", res16, 0);
        #2 rst = 0;
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick("t6");
        chk("t6.p_zero", res16, 0);
        chk("t6.val_cap", val16, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(16'($urandom_range(0, 65535)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0);
            tick("rnd");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/mul_datapath.md
Name: mul_datapath

Overview:
Datapath stage driven by the multiplier controller. It implements the repeated-addition multiplier that produces P = A × B:
- operand register A;
- down-counter B, which generates `eqz` back to the controller;
- product accumulator P.
It also captures the final product into an output register with a valid/ready handshake, so downstream logic can consume the result.

Parameters:
- WIDTH, 16, operand width of A, B and `data_in`.
- P_WIDTH, 32, width of accumulator P and `result`. Must be ≥ WIDTH. Arithmetic is modulo 2^P_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  shared operand bus; loaded into A on LdA, into B on LdB.
- LdA  in  1  load A from `data_in`.
- LdB  in  1  load B from `data_in`.
- LdP  in  1  accumulate: P <= P + A.
- clrP  in  1  clear P.
- decB  in  1  decrement B.
- done  in  1  controller completion (level, held high while controller is in its final state).
- eqz  out  1  B == 0, combinational from B register.
- result  out  P_WIDTH  captured product.
- res_valid  out  1  `result` holds an unconsumed product.
- res_ready  in  1  downstream accepts `result`.

Behaviour:
- Reset (async, immediate): A = 0, B = 0, P = 0, result = 0, res_valid = 0, done_q = 0. `eqz` therefore reads 1 during and after reset.
- A register:
  - LdA -> A <= data_in;
  - otherwise hold.
- B register:
  - LdB has priority -> B <= data_in;
  - else decB with B != 0 -> B <= B - 1;
  - decB with B == 0 -> B holds 0 (no wrap).
- LdA and LdB together: both load the same `data_in` value. This is legal.
- P register:
  - clrP has priority -> P <= 0;
  - else LdP -> P <= P + zero-extended A, truncated to P_WIDTH;
  - otherwise hold.
- Simultaneous LdP and decB in the same cycle are independent; both take effect.
- eqz: purely combinational, (B == 0). It reflects the registered B, so a decrement to 0 is visible the cycle after the decB edge.
- Result capture:
  - done_q <= done every cycle.
  - On the rising edge of done (done & ~done_q): result <= current P (pre-edge value) and res_valid <= 1.
- Handshake:
  - res_valid & res_ready -> res_valid <= 0 next edge.
  - `result` holds its value until the next capture.
- Capture in the same cycle as an accepting handshake: the capture wins; res_valid stays 1 with the new value.
- Capture while res_valid is already 1 and unaccepted: the old value is overwritten. Downstream must keep res_ready high or accept losses; no backpressure goes to the controller.
- done held high: only one capture. A new capture requires done to fall and rise again.
- Reset mid-operation: all state clears asynchronously and any pending result is discarded.
- Latency: `result` and `res_valid` valid 1 cycle after done rises.

Optional Feature:
- Macro: MUL_OVF_FLAG_EN.
- Defined:
  - adds output port `ovf` (1 bit), a sticky flag;
  - set when an LdP accumulation carries out of bit P_WIDTH-1;
  - cleared by clrP (clrP wins over a same-cycle set) and by rst;
  - `ovf` is also captured alongside `result` at the done rising edge, as `res_ovf`.
- Not defined: no `ovf`/`res_ovf` ports; carries are silently discarded.

Decomposition:
- Shared package mul_pkg holds:
  - default WIDTH and P_WIDTH constants;
  - a packed struct typedef bundling the control signals {LdA, LdB, LdP, clrP, decB}, for controller/datapath binding in testbenches.
- One natural sub-module: mul_down_counter (WIDTH), with load, saturating decrement and zero flag. It implements B and `eqz`.

Test Plan:
1. Normal multiply:
   - stimulus: rst pulse; data_in = 17 with LdA; data_in = 5 with LdB + clrP; then LdP + decB for 5 cycles; then done.
   - response: eqz = 1 after the 5th decrement, P = 85; one cycle after done rises, result = 85 and res_valid = 1.
2. Zero operand:
   - stimulus: LdB with data_in = 0; then decB for 3 cycles.
   - response: B stays 0, eqz = 1 throughout.
   - stimulus: LdA = 9, clrP, done.
   - response: result = 0.
3. Priority:
   - stimulus: clrP and LdP asserted together with A = 3, P = 12; then LdB = 7 and decB together.
   - response: P = 0, then B = 7.
4. Wrap and overflow (WIDTH = 8, P_WIDTH = 8, MUL_OVF_FLAG_EN defined):
   - stimulus: A = 200, B = 2, two accumulations.
   - response: P = 144 (400 mod 256), ovf = 1; clrP clears ovf.
5. Handshake:
   - stimulus: done rises with P = 42 and res_ready = 0 for 4 cycles.
   - response: res_valid stays 1 and result stays 42; with res_ready = 1 for one cycle, res_valid = 0 next cycle.
   - stimulus: done held high.
   - response: no re-capture.
6. Reset mid-operation:
   - stimulus: assert rst asynchronously (between edges) while P = 30 and res_valid = 1.
   - response: immediately P = 0, B = 0, eqz = 1, res_valid = 0, result = 0.
